// File: rtl/btb_assoc_array_pkg.sv
// Shared types and constants for the set-associative BTB storage.
// Localparams mirror the default configuration of btb_assoc_array.
package btb_pkg;

    localparam int S_INDEX    = 4;
    localparam int WAYS       = 4;
    localparam int TAG_W      = 26;
    localparam int TARGET_W   = 30;
    localparam int PLRU_NODES = WAYS - 1;

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [TARGET_W-1:0] target;
    } btb_entry_t;

    function automatic int plru_nodes(input int ways);
        return ways - 1;
    endfunction

endpackage

// File: rtl/btb_assoc_array_plru_tree.sv
// Combinational tree-PLRU: next-state bits after touching a way, and the current victim.
// Heap-ordered nodes (children of n are 2n+1, 2n+2); bit 0 means the victim is in the lower half.
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         cur_bits,
    input  logic [$clog2(WAYS)-1:0] touch_way,
    output logic [WAYS-2:0]         next_bits,
    output logic [$clog2(WAYS)-1:0] victim
);
    localparam int LVL = $clog2(WAYS);

    always_comb begin
        int node;
        int vnode;
        next_bits = cur_bits;
        node      = 0;
        vnode     = 0;
        for (int l = 0; l < LVL; l++) begin
            // Point each node on the touched path at the opposite subtree.
            next_bits[node] = ~touch_way[LVL-1-l];
            node  = 2 * node + 1 + int'(touch_way[LVL-1-l]);
            vnode = 2 * vnode + 1 + int'(cur_bits[vnode]);
        end
        victim = LVL'(vnode - (WAYS - 1));
    end

endmodule

// File: rtl/btb_assoc_array.sv
// Set-associative BTB array: registered 1-cycle lookup (read-old-data), same-edge update/allocate.
// Tree-PLRU replacement per set; single-cycle flush clears valid and PLRU state.
module btb_assoc_array #(
    parameter int S_INDEX  = 4,
    parameter int WAYS     = 4,
    parameter int TAG_W    = 26,
    parameter int TARGET_W = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    lk_req,
    input  logic [S_INDEX-1:0]      lk_index,
    input  logic [TAG_W-1:0]        lk_tag,
    output logic                    lk_rsp_valid,
    output logic                    lk_hit,
    output logic [$clog2(WAYS)-1:0] lk_way,
    output logic [TARGET_W-1:0]     lk_target,
    input  logic                    up_req,
    input  logic [S_INDEX-1:0]      up_index,
    input  logic [TAG_W-1:0]        up_tag,
    input  logic [TARGET_W-1:0]     up_target,
    input  logic                    up_inval
);
    import btb_pkg::*;

    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int WAY_W    = $clog2(WAYS);
    localparam int NODES    = plru_nodes(WAYS);

    logic [WAYS-1:0]     valid_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][WAYS];
    logic [TARGET_W-1:0] tgt_q   [NUM_SETS][WAYS];
    logic [NODES-1:0]    plru_q  [NUM_SETS];

    logic                lk_hit_c;
    logic [WAY_W-1:0]    lk_way_c;
    logic [TARGET_W-1:0] lk_tgt_c;
    logic                up_hit_c;
    logic [WAY_W-1:0]    up_way_c;
    logic                free_c;
    logic [WAY_W-1:0]    free_way_c;

    always_comb begin
        lk_hit_c   = 1'b0;
        lk_way_c   = '0;
        lk_tgt_c   = '0;
        up_hit_c   = 1'b0;
        up_way_c   = '0;
        free_c     = 1'b0;
        free_way_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_index][w] && tag_q[lk_index][w] == lk_tag) begin
                lk_hit_c = 1'b1;
                lk_way_c = WAY_W'(w);
                lk_tgt_c = tgt_q[lk_index][w];
            end
            if (valid_q[up_index][w] && tag_q[up_index][w] == up_tag) begin
                up_hit_c = 1'b1;
                up_way_c = WAY_W'(w);
            end
        end
        // Scan downwards so the lowest-numbered invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[up_index][w]) begin
                free_c     = 1'b1;
                free_way_c = WAY_W'(w);
            end
        end
    end

    logic             lk_touch;
    logic [NODES-1:0] lk_plru_next;
    logic [WAY_W-1:0] lk_victim_unused;
    logic [NODES-1:0] up_plru_cur;
    logic [NODES-1:0] up_plru_next;
    logic [WAY_W-1:0] up_victim;
    logic [WAY_W-1:0] up_way_sel;
    logic             up_write;
    logic             up_clear;

    assign lk_touch = lk_req && lk_hit_c;

    plru_tree #(.WAYS(WAYS)) u_lk_plru (
        .cur_bits  (plru_q[lk_index]),
        .touch_way (lk_way_c),
        .next_bits (lk_plru_next),
        .victim    (lk_victim_unused)
    );

    // A same-set lookup touch is applied before the update touch, so chain them.
    assign up_plru_cur = (lk_touch && lk_index == up_index) ? lk_plru_next : plru_q[up_index];

    plru_tree #(.WAYS(WAYS)) u_up_plru (
        .cur_bits  (up_plru_cur),
        .touch_way (up_way_sel),
        .next_bits (up_plru_next),
        .victim    (up_victim)
    );

    assign up_way_sel = up_hit_c ? up_way_c : (free_c ? free_way_c : up_victim);
    assign up_write   = up_req && !flush && !up_inval;
    assign up_clear   = up_req && !flush && up_inval && up_hit_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_rsp_valid <= 1'b0;
            lk_hit       <= 1'b0;
            lk_way       <= '0;
            lk_target    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            lk_rsp_valid <= lk_req;
            lk_hit       <= lk_touch;
            lk_way       <= lk_req ? lk_way_c : '0;
            lk_target    <= lk_req ? lk_tgt_c : '0;
            if (flush) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_q[s] <= '0;
                    plru_q[s]  <= '0;
                end
            end else begin
                if (lk_touch) plru_q[lk_index] <= lk_plru_next;
                if (up_write) begin
                    valid_q[up_index][up_way_sel] <= 1'b1;
                    plru_q[up_index]              <= up_plru_next;
                end
                if (up_clear) valid_q[up_index][up_way_c] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (up_write) begin
            tag_q[up_index][up_way_sel] <= up_tag;
            tgt_q[up_index][up_way_sel] <= up_target;
        end
    end

endmodule

// File: tb/tb_btb_assoc_array.sv
// Directed bench for btb_assoc_array with hand-computed lookup responses.
// Response word = {lk_rsp_valid, lk_hit, lk_way, lk_target}.
module tb_btb_assoc_array;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        lk_req;
    logic [3:0]  lk_index;
    logic [25:0] lk_tag;
    logic        lk_rsp_valid;
    logic        lk_hit;
    logic [1:0]  lk_way;
    logic [29:0] lk_target;
    logic        up_req;
    logic [3:0]  up_index;
    logic [25:0] up_tag;
    logic [29:0] up_target;
    logic        up_inval;

    int checks = 0;
    int errors = 0;

    btb_assoc_array #(.S_INDEX(4), .WAYS(4), .TAG_W(26), .TARGET_W(30)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .lk_req       (lk_req),
        .lk_index     (lk_index),
        .lk_tag       (lk_tag),
        .lk_rsp_valid (lk_rsp_valid),
        .lk_hit       (lk_hit),
        .lk_way       (lk_way),
        .lk_target    (lk_target),
        .up_req       (up_req),
        .up_index     (up_index),
        .up_tag       (up_tag),
        .up_target    (up_target),
        .up_inval     (up_inval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] rsp();
        return {lk_rsp_valid, lk_hit, lk_way, lk_target};
    endfunction

    function automatic logic [33:0] mk(input logic v, input logic h, input logic [1:0] w,
                                       input logic [29:0] t);
        return {v, h, w, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        lk_req   = 1'b0;
        up_req   = 1'b0;
        up_inval = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic set_lk(input logic [3:0] idx, input logic [25:0] tag);
        lk_req   = 1'b1;
        lk_index = idx;
        lk_tag   = tag;
    endtask

    task automatic set_up(input logic [3:0] idx, input logic [25:0] tag, input logic [29:0] tgt,
                          input logic inval);
        up_req    = 1'b1;
        up_index  = idx;
        up_tag    = tag;
        up_target = tgt;
        up_inval  = inval;
    endtask

    task automatic test_reset();
        checks++;
        if (rsp() !== 34'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", rsp(), 34'h0);
        end
        set_lk(4'd3, 26'h5);
        step();
        checks++;
        if (rsp() !== mk(1, 0, 0, 0)) begin
            errors++;
            $display("FAIL first_miss: got %h want %h", rsp(), mk(1, 0, 0, 0));
        end
    endtask

    task automatic test_update_lookup();
        set_up(4'd3, 26'h5, 30'h100, 0);
        set_lk(4'd3, 26'h5);
        step();
        checks++;
        if (rsp() !== mk(1, 0, 0, 0)) begin
            errors++;
            $display("FAIL same_cycle_miss: got %h want %h", rsp(), mk(1, 0, 0, 0));
        end
        set_lk(4'd3, 26'h5);
        step();
        checks++;
        if (rsp() !== mk(1, 1, 0, 30'h100)) begin
            errors++;
            $display("FAIL next_cycle_hit: got %h want %h", rsp(), mk(1, 1, 0, 30'h100));
        end
        step();
        checks++;
        if (rsp() !== 34'h0) begin
            errors++;
            $display("FAIL idle_zero: got %h want %h", rsp(), 34'h0);
        end
    endtask

    task automatic test_plru_replace();
        for (int i = 1; i <= 4; i++) begin
            set_up(4'd2, 26'(i), 30'(32'h10 + i), 0);
            step();
        end
        // Touch way 0 then way 2: root points left, left node points at way 1.
        set_lk(4'd2, 26'h1);
        step();
        checks++;
        if (rsp() !== mk(1, 1, 0, 30'h11)) begin
            errors++;
            $display("FAIL fill_hit_tag1: got %h want %h", rsp(), mk(1, 1, 0, 30'h11));
        end
        set_lk(4'd2, 26'h3);
        step();
        checks++;
        if (rsp() !== mk(1, 1, 2, 30'h13)) begin
            errors++;
            $display("FAIL fill_hit_tag3: got %h want %h", rsp(), mk(1, 1, 2, 30'h13));
        end
        set_up(4'd2, 26'h5, 30'h15, 0);
        step();
        set_lk(4'd2, 26'h5);
        step();
        checks++;
        if (rsp() !== mk(1, 1, 1, 30'h15)) begin
            errors++;
            $display("FAIL victim_way1: got %h want %h", rsp(), mk(1, 1, 1, 30'h15));
        end
        set_lk(4'd2, 26'h2);
        step();
        checks++;
        if (rsp() !== mk(1, 0, 0, 0)) begin
            errors++;
            $display("FAIL evicted_tag2: got %h want %h", rsp(), mk(1, 0, 0, 0));
        end
        set_lk(4'd2, 26'h1);
        step();
        checks++;
        if (rsp() !== mk(1, 1, 0, 30'h11)) begin
            errors++;
            $display("FAIL kept_tag1: got %h want %h", rsp(), mk(1, 1, 0, 30'h11));
        end
    endtask

    task automatic test_overwrite_inval();
        set_up(4'd2, 26'h3, 30'h200, 0);
        step();
        set_lk(4'd2, 26'h3);
        step();
        checks++;
        if (rsp() !== mk(1, 1, 2, 30'h200)) begin
            errors++;
            $display("FAIL overwrite_tag3: got %h want %h", rsp(), mk(1, 1, 2, 30'h200));
        end
        set_lk(4'd2, 26'h4);
        step();
        checks++;
        if (rsp() !== mk(1, 1, 3, 30'h14)) begin
            errors++;
            $display("FAIL untouched_tag4: got %h want %h", rsp(), mk(1, 1, 3, 30'h14));
        end
        set_up(4'd2, 26'h3, 30'h0, 1);
        step();
        set_lk(4'd2, 26'h3);
        step();
        checks++;
        if (rsp() !== mk(1, 0, 0, 0)) begin
            errors++;
            $display("FAIL inval_tag3: got %h want %h", rsp(), mk(1, 0, 0, 0));
        end
        // Inval on a missing tag is a no-op; the freed way 2 is then the lowest invalid.
        set_up(4'd2, 26'h77, 30'h0, 1);
        step();
        set_up(4'd2, 26'h6, 30'h66, 0);
        step();
        set_lk(4'd2, 26'h6);
        step();
        checks++;
        if (rsp() !== mk(1, 1, 2, 30'h66)) begin
            errors++;
            $display("FAIL refill_lowest_invalid: got %h want %h", rsp(), mk(1, 1, 2, 30'h66));
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        set_up(4'd4, 26'h9, 30'h99, 0);
        set_lk(4'd2, 26'h1);
        step();
        checks++;
        if (rsp() !== mk(1, 1, 0, 30'h11)) begin
            errors++;
            $display("FAIL flush_preflush_rsp: got %h want %h", rsp(), mk(1, 1, 0, 30'h11));
        end
        set_lk(4'd4, 26'h9);
        step();
        checks++;
        if (rsp() !== mk(1, 0, 0, 0)) begin
            errors++;
            $display("FAIL flush_drops_update: got %h want %h", rsp(), mk(1, 0, 0, 0));
        end
        set_lk(4'd2, 26'h1);
        step();
        checks++;
        if (rsp() !== mk(1, 0, 0, 0)) begin
            errors++;
            $display("FAIL flush_set2: got %h want %h", rsp(), mk(1, 0, 0, 0));
        end
        set_lk(4'd3, 26'h5);
        step();
        checks++;
        if (rsp() !== mk(1, 0, 0, 0)) begin
            errors++;
            $display("FAIL flush_set3: got %h want %h", rsp(), mk(1, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        set_up(4'd5, 26'h7, 30'h70, 0);
        set_lk(4'd5, 26'h7);
        step();
        checks++;
        if (rsp() !== mk(1, 0, 0, 0)) begin
            errors++;
            $display("FAIL b2b_c1: got %h want %h", rsp(), mk(1, 0, 0, 0));
        end
        set_up(4'd5, 26'h8, 30'h80, 0);
        set_lk(4'd5, 26'h7);
        step();
        checks++;
        if (rsp() !== mk(1, 1, 0, 30'h70)) begin
            errors++;
            $display("FAIL b2b_c2: got %h want %h", rsp(), mk(1, 1, 0, 30'h70));
        end
        set_lk(4'd5, 26'h8);
        step();
        checks++;
        if (rsp() !== mk(1, 1, 1, 30'h80)) begin
            errors++;
            $display("FAIL b2b_c3: got %h want %h", rsp(), mk(1, 1, 1, 30'h80));
        end
    endtask

    task automatic test_async_reset();
        set_up(4'd6, 26'hA, 30'h3A, 0);
        step();
        set_lk(4'd6, 26'hA);
        step();
        checks++;
        if (rsp() !== mk(1, 1, 0, 30'h3A)) begin
            errors++;
            $display("FAIL pre_reset_hit: got %h want %h", rsp(), mk(1, 1, 0, 30'h3A));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rsp() !== 34'h0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h want %h", rsp(), 34'h0);
        end
        #3 rst = 1'b0;
        set_lk(4'd6, 26'hA);
        step();
        checks++;
        if (rsp() !== mk(1, 0, 0, 0)) begin
            errors++;
            $display("FAIL post_reset_miss: got %h want %h", rsp(), mk(1, 0, 0, 0));
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        lk_req    = 1'b0;
        lk_index  = '0;
        lk_tag    = '0;
        up_req    = 1'b0;
        up_index  = '0;
        up_tag    = '0;
        up_target = '0;
        up_inval  = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_update_lookup();
        test_plru_replace();
        test_overwrite_inval();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
